// File: rtl/johnson_decoder.sv
// Decodes and tracks an 8-bit Johnson counter: index decode, successor lock, error pulses.
// Define JOHNSON_DECODER_ERR_CNT_EN to build the saturating error counter; otherwise err_cnt is tied to 0.
module johnson_decoder #(
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic [3:0] count_out,
  output logic       count_valid,
  output logic       locked,
  output logic       code_err,
  output logic       seq_err,
  output logic [7:0] err_cnt
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       ref_valid_q, ref_valid_d;
  logic [7:0] ref_code_q, ref_code_d;
  logic [2:0] match_q, match_d;
  logic [3:0] count_q, count_d;
  logic       count_valid_q, count_valid_d;
  logic       code_err_q, code_err_d;
  logic       seq_err_q, seq_err_d;

  // A legal Johnson word has at most one 0/1 boundary between adjacent bits.
  logic [6:0] edges;
  logic       is_legal;
  logic       is_succ;
  logic [3:0] ones;
  logic [3:0] index;
  logic [2:0] match_inc;

  always_comb begin
    edges     = code_in[6:0] ^ code_in[7:1];
    is_legal  = (edges & (edges - 7'd1)) == 7'd0;
    is_succ   = ref_valid_q && (code_in == {ref_code_q[6:0], ~ref_code_q[7]});
    ones      = 4'd0;
    for (int i = 0; i < 8; i++) ones = ones + {3'd0, code_in[i]};
    index     = code_in[7] ? 4'(5'd16 - {1'b0, ones}) : ones;
    match_inc = match_q + 3'd1;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_d       = state_q;
    ref_valid_d   = ref_valid_q;
    ref_code_d    = ref_code_q;
    match_d       = match_q;
    count_d       = count_q;
    count_valid_d = count_valid_q;
    code_err_d    = 1'b0;
    seq_err_d     = 1'b0;

    if (code_valid) begin
      if (!is_legal) begin
        code_err_d    = 1'b1;
        count_valid_d = 1'b0;
        state_d       = SEARCH;
        match_d       = 3'd0;
      end else begin
        count_d       = index;
        count_valid_d = 1'b1;
        ref_code_d    = code_in;
        ref_valid_d   = 1'b1;
        unique case (state_q)
          SEARCH: begin
            if (ref_valid_q && is_succ) begin
              if (match_inc == 3'(LOCK_CNT)) begin
                state_d = LOCKED;
                match_d = 3'd0;
              end else begin
                match_d = match_inc;
              end
            end else begin
              match_d = 3'd0;
            end
          end
          LOCKED: begin
            if (!is_succ) begin
              seq_err_d = 1'b1;
              state_d   = SEARCH;
              match_d   = 3'd0;
            end
          end
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      ref_valid_q   <= 1'b0;
      ref_code_q    <= 8'd0;
      match_q       <= 3'd0;
      count_q       <= 4'd0;
      count_valid_q <= 1'b0;
      code_err_q    <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_valid_q   <= ref_valid_d;
      ref_code_q    <= ref_code_d;
      match_q       <= match_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      code_err_q    <= code_err_d;
      seq_err_q     <= seq_err_d;
    end
  end

`ifdef JOHNSON_DECODER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else if ((code_err_d || seq_err_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign count_out   = count_q;
  assign count_valid = count_valid_q;
  assign locked      = (state_q == LOCKED);
  assign code_err    = code_err_q;
  assign seq_err     = seq_err_q;

endmodule

// File: doc/johnson_decoder.md
JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter LOCK_CNT, default 2, meaning consecutive correct successor codes required to enter LOCKED (legal range 1..7).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 code_in  input  8  Johnson code word from the counter under observation.
REQ-005 code_valid  input  1  code_in sampled only when high.
REQ-006 count_out  output  4  decoded index 0..15 of last legal code.
REQ-007 count_valid  output  1  high when count_out reflects the most recent sample.
REQ-008 locked  output  1  high in LOCKED state.
REQ-009 code_err  output  1  one-cycle pulse: illegal code sampled.
REQ-010 seq_err  output  1  one-cycle pulse: legal code that is not the expected successor while LOCKED.
REQ-011 err_cnt  output  8  saturating count of code_err plus seq_err events.

Function
REQ-012 Legal codes SHALL be exactly 0^a1^b or 1^a0^b over bits [7:0] (a+b=8), 16 words total.
REQ-013 Successor of legal code c SHALL be {c[6:0], ~c[7]}; 00000000 -> 00000001 -> ... -> 11111111 -> 11111110 -> ... -> 10000000 -> 00000000.
REQ-014 Decode SHALL be: c[7]=0 -> popcount(c); c[7]=1 -> 16 - popcount(c) (11111111=8, 10000000=15).
REQ-015 All outputs SHALL be registered; response to a sample SHALL appear the cycle after code_valid is sampled high (latency 1).
REQ-016 code_valid low SHALL hold state, count_out, count_valid, locked and err_cnt; code_err and seq_err SHALL be 0.
REQ-017 Illegal sample: code_err=1, count_valid=0, count_out held, state -> SEARCH, match counter cleared, seq_err=0 (code_err has priority).
REQ-018 Legal sample: count_out=decoded index, count_valid=1, stored previous code updated.
REQ-019 States SHALL be SEARCH and LOCKED.
REQ-020 SEARCH: first legal sample loads reference only; each following legal sample equal to successor of the previous increments the match counter; a non-successor legal sample sets match counter to 0 with no seq_err.
REQ-021 SEARCH -> LOCKED when match counter reaches LOCK_CNT; locked asserts in the same cycle as the count_out of that sample.
REQ-022 LOCKED: successor sample stays LOCKED; legal non-successor sample pulses seq_err, -> SEARCH, new sample becomes reference, match counter 0.
REQ-023 Wrap-around 10000000 -> 00000000 SHALL count as a correct successor.
REQ-024 A repeated identical code SHALL be treated as a non-successor.
REQ-025 err_cnt SHALL increment by 1 per error event and saturate at 255.

Reset
REQ-026 reset SHALL take priority over code_valid in the same cycle.
REQ-027 On reset: state SEARCH, no reference held, match counter 0, count_out=0, count_valid=0, locked=0, code_err=0, seq_err=0, err_cnt=0.
REQ-028 reset mid-stream SHALL discard the reference; the next legal sample is treated as a first sample.

Configuration
REQ-029 Macro JOHNSON_DECODER_ERR_CNT_EN: when defined, err_cnt SHALL be implemented per REQ-025.
REQ-030 When not defined, err_cnt SHALL be constant 0 with no counter register; all other behaviour unchanged.

Verification
REQ-031 reset 2 cycles, then feed the 16-code sequence from 00000000 with code_valid=1 each cycle -> count_out 0..15 one cycle later, locked=1 after third sample (LOCK_CNT=2), no errors.
REQ-032 While LOCKED at 00000111, sample 00011111 -> seq_err pulse, locked=0, count_out=5, err_cnt=1.
REQ-033 Sample 01010101 -> code_err pulse, count_valid=0, count_out unchanged, locked=0.
REQ-034 LOCKED sequence through 10000000 -> 00000000 -> count_out 15 then 0, locked stays 1, no seq_err.
REQ-035 Assert reset coincident with code_valid=1 and an illegal code while LOCKED -> all outputs 0 next cycle, no code_err.
REQ-036 300 illegal samples (macro defined) -> err_cnt=255 held; macro undefined -> err_cnt=0 throughout.
